uart_tx_framed: RTL
===================

// Module: uart_tx_framed
// PURPOSE
//  Parametrised UART transmitter: configurable data width, oversampling ratio, parity and stop bits.
//  A one-word holding buffer allows back-to-back frames with no idle gap on the line.
//  Sits in the debug unit between the baud-rate generator (supplies i_baud_rate ticks) and the TX pin.
//  Driven by the debug FSM through a start/ready handshake.
// PARAMETERS
//  NBITS       8   data bits per frame (5..9), sent LSB first
//  OVERSAMPLE  16  i_baud_rate ticks per bit period (>=2)
//  PARITY      0   0 = none, 1 = even, 2 = odd
//  STOP_BITS   1   number of stop bits (1 or 2)
// PORTS
//  clk          in   1      system clock; all logic on posedge
//  rst          in   1      synchronous, active-low reset
//  i_baud_rate  in   1      one-clk tick, OVERSAMPLE per bit period
//  i_tx_start   in   1      request to send i_data; accepted only when o_tx_ready=1
//  i_data       in   NBITS  word to send; sampled in the accepting cycle
//  o_tx_ready   out  1      holding buffer empty; a start is accepted this cycle
//  o_tx_done    out  1      1 = line idle and buffer empty (nothing pending)
//  o_tx         out  1      serial line, idle high
// BEHAVIOUR
//  Reset (rst=0 at posedge): state=IDLE, counters=0, buffer cleared, o_tx=1, o_tx_done=1, o_tx_ready=1.
//   Reset mid-frame aborts the frame; o_tx returns high at that edge.
//  All outputs registered or decoded from registers only; no combinational path from inputs.
//  Handshake: accept = i_tx_start & o_tx_ready. Accepted data goes to the holding buffer
//   (buf_full <= 1). i_tx_start while o_tx_ready=0 is ignored; data is lost, no error flag.
//  o_tx_ready = !buf_full. o_tx_done = (state==IDLE) & !buf_full.
//  Shifter load:
//   - In IDLE with buf_full: move buffer to shift reg, clear buf_full, enter START.
//   - o_tx falls on the clk edge after entry into START (one clk after the accept cycle when idle).
//  Frame states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE/START.
//  Each bit is held exactly OVERSAMPLE i_baud_rate ticks. tick_cnt counts ticks 0..OVERSAMPLE-1.
//   The bit ends on the tick where tick_cnt==OVERSAMPLE-1; tick_cnt then wraps to 0.
//  START: o_tx=0 for one bit period.
//  DATA: o_tx = shift[0]; shift right each bit; bit_cnt 0..NBITS-1; leave after bit NBITS-1.
//  PARITY (only if PARITY!=0): o_tx = ^data (even) or ~^data (odd), computed from the loaded word.
//  STOP: o_tx=1 for STOP_BITS bit periods.
//   At the end of the last stop bit: if buf_full, load and go directly to START (zero-gap
//   back-to-back); else go to IDLE.
//  Simultaneous accept and end-of-stop in the same cycle: the new word is stored in the buffer
//   and loaded on the next clk. The gap is one clk, not one bit.
//  Ticks arriving in IDLE are ignored. tick_cnt is cleared on every entry to START.
//  Frame length = (1 + NBITS + (PARITY!=0) + STOP_BITS) * OVERSAMPLE ticks.
//  Widths:
//   tick_cnt: $clog2(OVERSAMPLE) bits
//   bit_cnt:  $clog2(NBITS+1) bits
//   stop_cnt: 1 bit
//  Counters never wrap past their terminal value.
// STRUCTURE
//  Shared package uart_pkg: state encodings (IDLE/START/DATA/PARITY/STOP),
//   parity mode constants PAR_NONE/PAR_EVEN/PAR_ODD.
//  Single always@(posedge clk) register block plus one always@* next-state block.
//  One natural sub-module: uart_tx_holdbuf (one-word valid/data register with load/take strobes).
// TESTING
//  1. Reset: hold rst=0 5 clks -> o_tx=1, o_tx_done=1, o_tx_ready=1.
//     Ticks with no start -> o_tx stays 1.
//  2. NBITS=8, OVERSAMPLE=16, PARITY=0, STOP=1: send 8'hA5 ->
//     line 0,1,0,1,0,0,1,0,1,1, each held exactly 16 ticks; o_tx_done=1 after 160 ticks.
//  3. PARITY=1 send 8'h07 -> parity bit 1; PARITY=2 send 8'h07 -> parity bit 0; STOP_BITS=2 -> 32 high ticks.
//  4. Back-to-back: accept 8'h55, then 8'hC3 mid-frame -> o_tx_ready=0 until the 2nd frame loads;
//     2nd start bit follows the 1st stop bit with no idle tick. A 3rd start while ready=0 is dropped.
//  5. Reset mid-DATA (after bit 3) -> o_tx=1 next edge, buffer empty;
//     a new frame after reset is bit-exact.
//  6. i_tx_start coincident with the final stop tick -> word buffered and sent starting 1 clk later;
//     no data corruption.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: frame states, parity modes
// and the parity helper used when a word is loaded into the shifter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // Callers zero-extend narrower words; the extra zeros do not change the result.
  function automatic logic parity_of(input int unsigned mode, input logic [8:0] word);
    return (mode == PAR_ODD) ? ~^word : ^word;
  endfunction

endpackage

// File: rtl/uart_tx_holdbuf.sv
// One-word holding register between the handshake and the shifter.
// load captures a word and marks it valid; take releases it.
module uart_tx_holdbuf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             take,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      full <= 1'b0;
      dout <= '0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end else if (take) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_framed.sv
// Parametrised UART transmitter with a one-word holding buffer so frames can
// run back to back with no idle gap on the line.
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int unsigned NBITS      = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_baud_rate,
  input  logic             i_tx_start,
  input  logic [NBITS-1:0] i_data,
  output logic             o_tx_ready,
  output logic             o_tx_done,
  output logic             o_tx
);

  localparam int unsigned TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BIT_W  = $clog2(NBITS + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(NBITS - 1);
  localparam logic              STOP_LAST = (STOP_BITS == 2);

  tx_state_t         state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              stop_q, stop_d;
  logic [NBITS-1:0]  shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;

  logic              buf_full;
  logic [NBITS-1:0]  buf_data;
  logic              accept;
  logic              take;
  logic              bit_end;

  assign accept  = i_tx_start & ~buf_full;
  assign bit_end = i_baud_rate && (tick_q == TICK_LAST);

  uart_tx_holdbuf #(.WIDTH(NBITS)) u_holdbuf (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .take (take),
    .din  (i_data),
    .full (buf_full),
    .dout (buf_data)
  );

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    take    = 1'b0;

    if (i_baud_rate && state_q != ST_IDLE)
      tick_d = bit_end ? '0 : tick_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (buf_full) take = 1'b1;
      end
      ST_START: begin
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            stop_d = 1'b0;
            if (buf_full) take = 1'b1;
            else          state_d = ST_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A word taken from the buffer always starts a fresh frame, from IDLE or
    // straight out of the final stop bit.
    if (take) begin
      shift_d = buf_data;
      par_d   = parity_of(PARITY, 9'(buf_data));
      state_d = ST_START;
      tick_d  = '0;
      bit_d   = '0;
      stop_d  = 1'b0;
    end

    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign o_tx       = tx_q;
  assign o_tx_ready = ~buf_full;
  assign o_tx_done  = (state_q == ST_IDLE) && !buf_full;

endmodule
